writeback_register_file: RTL and testbench

Writeback stage and architectural register file of the pipelined MIPS core, fed directly by the memory-to-writeback pipeline register. Selects the writeback result (load data or ALU result) and commits it to a 32-entry general-purpose register file. Provides the two combinational read ports used by the decode stage, and keeps a count of committed register writes for debug and performance.

---
 rtl/writeback_register_file_pkg.sv | 11 +
 rtl/writeback_register_file_regfile_core.sv | 36 +++
 rtl/writeback_register_file.sv | 49 ++++
 tb/tb_writeback_register_file.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/writeback_register_file_pkg.sv
// writeback_register_file_pkg: shared widths, register-zero index and result-select encoding
package writeback_register_file_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int REG_ZERO = 0;
  typedef enum logic {
    RES_ALU = 1'b0,
    RES_MEM = 1'b1
  } result_sel_e;
endpackage

// File: rtl/writeback_register_file_regfile_core.sv
// regfile_core: 2-read/1-write register array, register 0 reads zero; write-through bypass when REGFILE_BYPASS_EN is defined
module regfile_core
  import writeback_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic [ADDR_WIDTH-1:0] a2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // storage: async clear, one write per edge; the caller never enables writes to register 0
  always_ff @(posedge CLK or negedge RST)
    if (!RST)
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    else if (we)
      mem[wa] <= wd;
  // read ports: register 0 forced to zero, optional same-cycle bypass of the pending write
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rd1 = (a1 == ZERO) ? '0 : (we && a1 == wa) ? wd : mem[a1];
    rd2 = (a2 == ZERO) ? '0 : (we && a2 == wa) ? wd : mem[a2];
`else
    rd1 = (a1 == ZERO) ? '0 : mem[a1];
    rd2 = (a2 == ZERO) ? '0 : mem[a2];
`endif
  end
endmodule

// File: rtl/writeback_register_file.sv
// writeback_register_file: writeback result mux, commit logic, commit counter and register file (option: REGFILE_BYPASS_EN)
module writeback_register_file
  import writeback_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] ALUOutW,
  input  logic [ADDR_WIDTH-1:0] WriteRegW,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [CNT_WIDTH-1:0]  WbCount
);
  logic commit;
  // result select and commit qualification; writes to register 0 are dropped here
  always_comb begin
    ResultW = (result_sel_e'(MemtoRegW) == RES_MEM) ? ReadDataW : ALUOutW;
    commit = RegWriteW && (WriteRegW != ADDR_WIDTH'(REG_ZERO));
  end
  // committed-write counter, wraps naturally
  always_ff @(posedge CLK or negedge RST)
    if (!RST)
      WbCount <= '0;
    else if (commit)
      WbCount <= WbCount + CNT_WIDTH'(1);
  regfile_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .CLK(CLK),
    .RST(RST),
    .we(commit),
    .wa(WriteRegW),
    .wd(ResultW),
    .a1(A1),
    .a2(A2),
    .rd1(RD1),
    .rd2(RD2)
  );
endmodule

// File: tb/tb_writeback_register_file.sv
// tb_writeback_register_file: random + directed self-check against an array model of the register file
module tb_writeback_register_file;
  localparam int CW = 4;
  logic CLK = 0, RST = 0;
  logic RegWriteW = 0, MemtoRegW = 0;
  logic [31:0] ReadDataW = 0, ALUOutW = 0;
  logic [4:0] WriteRegW = 0, A1 = 0, A2 = 0;
  logic [31:0] RD1, RD2, ResultW;
  logic [CW-1:0] WbCount;
  int total = 0, bad = 0;
  bit chk = 0;
  logic [31:0] m_regs [32];
  logic [CW-1:0] m_cnt;

  writeback_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .WbCount(WbCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] m_result();
    return MemtoRegW ? ReadDataW : ALUOutW;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWriteW && a == WriteRegW) return m_result();
`endif
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge RST) m_clear();

  always @(posedge CLK)
    if (RST && RegWriteW && WriteRegW != 0) begin
      m_regs[WriteRegW] = m_result();
      m_cnt = m_cnt + 1'b1;
    end

  always @(negedge CLK)
    if (chk) begin
      check("model_rd1", RD1, m_read(A1));
      check("model_rd2", RD2, m_read(A2));
      check("model_result", ResultW, m_result());
      check("model_cnt", {28'h0, WbCount}, {28'h0, m_cnt});
    end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    m_clear();
    repeat (2) step();
    RST = 1;
    chk = 1;
    @(negedge CLK);
    check("reset_rd1", RD1, 32'h0);
    check("reset_cnt", {28'h0, WbCount}, 32'h0);
    step();
    RegWriteW = 1; MemtoRegW = 1; ReadDataW = 32'hDEADBEEF; ALUOutW = 32'h12345678;
    WriteRegW = 8; A1 = 8;
    @(negedge CLK);
    check("sel_mem", ResultW, 32'hDEADBEEF);
    step();
    MemtoRegW = 0; WriteRegW = 9; A2 = 9;
    @(negedge CLK);
    check("commit_mem_rd1", RD1, 32'hDEADBEEF);
    check("commit_mem_cnt", {28'h0, WbCount}, 32'd1);
    check("sel_alu", ResultW, 32'h12345678);
    step();
    RegWriteW = 0;
    @(negedge CLK);
    check("commit_alu_rd2", RD2, 32'h12345678);
    check("commit_alu_cnt", {28'h0, WbCount}, 32'd2);
    RegWriteW = 1; MemtoRegW = 1; ReadDataW = 32'hFFFFFFFF; WriteRegW = 0; A1 = 0;
    step();
    RegWriteW = 0;
    @(negedge CLK);
    check("zero_rd1", RD1, 32'h0);
    check("zero_cnt", {28'h0, WbCount}, 32'd2);
    RegWriteW = 0; MemtoRegW = 1; ReadDataW = 32'hAAAA5555; WriteRegW = 5; A1 = 5;
    step();
    @(negedge CLK);
    check("nowe_rd1", RD1, 32'h0);
    check("nowe_cnt", {28'h0, WbCount}, 32'd2);
    RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'h1; WriteRegW = 10;
    step();
    ALUOutW = 32'h2; A1 = 10; A2 = 10;
    @(negedge CLK);
`ifdef REGFILE_BYPASS_EN
    check("same_pre_rd1", RD1, 32'h2);
    check("same_pre_rd2", RD2, 32'h2);
`else
    check("same_pre_rd1", RD1, 32'h1);
    check("same_pre_rd2", RD2, 32'h1);
`endif
    step();
    RegWriteW = 0;
    @(negedge CLK);
    check("same_post_rd1", RD1, 32'h2);
    check("same_post_rd2", RD2, 32'h2);
    check("same_post_cnt", {28'h0, WbCount}, 32'd4);
    step();
    RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'h7; WriteRegW = 11;
    RST = 0;
    #2;
    check("async_rd1", RD1, 32'h0);
    check("async_rd2", RD2, 32'h0);
    check("async_cnt", {28'h0, WbCount}, 32'd0);
    step();
    RST = 1; RegWriteW = 0; A1 = 11;
    @(negedge CLK);
    check("lost_write", RD1, 32'h0);
    for (int i = 0; i < 15; i++) begin
      RegWriteW = 1; MemtoRegW = 0; ALUOutW = 32'(i + 100); WriteRegW = 5'(1 + i);
      step();
    end
    @(negedge CLK);
    check("wrap_pre", {28'h0, WbCount}, 32'd15);
    step();
    RegWriteW = 0;
    @(negedge CLK);
    check("wrap_post", {28'h0, WbCount}, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      step();
      RST = ($urandom_range(0, 199) != 0);
      RegWriteW = ($urandom_range(0, 3) != 0);
      MemtoRegW = 1'($urandom);
      ReadDataW = $urandom;
      ALUOutW = $urandom;
      WriteRegW = 5'($urandom);
      A1 = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom);
      A2 = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom);
    end
    step();
    RST = 1;
    RegWriteW = 0;
    @(negedge CLK);
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
